// File: rtl/echo_loopback_buffer.sv
// AXI4-Stream echo buffer: rx beats are queued in a small FIFO and replayed on tx,
// either as soon as buffered (pass-through) or once a whole packet is held (store-and-forward).
module echo_loopback_buffer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic                      s_axis_rx_TVALID,
  output logic                      s_axis_rx_TREADY,
  input  logic [DATA_W-1:0]         s_axis_rx_TDATA,
  input  logic [DATA_W/8-1:0]       s_axis_rx_TKEEP,
  input  logic                      s_axis_rx_TLAST,

  output logic                      m_axis_tx_TVALID,
  input  logic                      m_axis_tx_TREADY,
  output logic [DATA_W-1:0]         m_axis_tx_TDATA,
  output logic [DATA_W/8-1:0]       m_axis_tx_TKEEP,
  output logic                      m_axis_tx_TLAST,

  input  logic                      mode,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [CNT_W-1:0]          pkt_cnt,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned KW = DATA_W / 8;
  localparam int unsigned BW = DATA_W + KW + 1;

  typedef logic [AW:0] occ_t;
  localparam occ_t Full = occ_t'(DEPTH);

  logic [BW-1:0]    mem [DEPTH];
  logic [BW-1:0]    rd_beat;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  occ_t             occ_q, occ_d;
  occ_t             cpl_q, cpl_d;
  logic             mode_q, mode_d;
  logic             in_pkt_q, in_pkt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic push, pop, push_last, pop_last, rx_stall;

  // Ready and valid depend only on registered state, so tx TREADY never reaches rx TREADY.
  assign s_axis_rx_TREADY = (occ_q < Full);
  assign m_axis_tx_TVALID = (occ_q != '0) && (!mode_q || (cpl_q != '0) || (occ_q == Full));

  assign rd_beat         = mem[rd_ptr_q];
  assign m_axis_tx_TDATA = rd_beat[BW-1 -: DATA_W];
  assign m_axis_tx_TKEEP = rd_beat[KW:1];
  assign m_axis_tx_TLAST = rd_beat[0];

  assign push      = s_axis_rx_TVALID && s_axis_rx_TREADY;
  assign pop       = m_axis_tx_TVALID && m_axis_tx_TREADY;
  assign push_last = push && s_axis_rx_TLAST;
  assign pop_last  = pop && rd_beat[0];
  assign rx_stall  = s_axis_rx_TVALID && !s_axis_rx_TREADY;

  assign occupancy = occ_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    cpl_d       = cpl_q;
    in_pkt_d    = in_pkt_q;
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    mode_d      = mode_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case ({push_last, pop_last})
      2'b10:   cpl_d = cpl_q + 1'b1;
      2'b01:   cpl_d = cpl_q - 1'b1;
      default: cpl_d = cpl_q;
    endcase

    if (pop) in_pkt_d = !rd_beat[0];
    if (pop_last) pkt_cnt_d = pkt_cnt_q + 1'b1;
    if (rx_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;

    // Switching mode only when idle keeps a packet from being split across policies.
    if ((occ_q == '0) && !in_pkt_q) mode_d = mode;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      cpl_q       <= '0;
      in_pkt_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
      mode_q      <= mode;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      cpl_q       <= cpl_d;
      in_pkt_q    <= in_pkt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mode_q      <= mode_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn && push) begin
      mem[wr_ptr_q] <= {s_axis_rx_TDATA, s_axis_rx_TKEEP, s_axis_rx_TLAST};
    end
  end

endmodule

// File: tb/tb_echo_loopback_buffer.sv
// Directed and random bench for echo_loopback_buffer: a negedge monitor scoreboards rx beats
// against tx beats while the stimulus thread walks through the directed scenarios.
module tb_echo_loopback_buffer;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned KW     = DATA_W / 8;

  typedef logic [DATA_W+KW:0] beat_t;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              s_valid, s_ready, s_last;
  logic [DATA_W-1:0] s_data;
  logic [KW-1:0]     s_keep;
  logic              tx_valid, tx_ready, tx_last;
  logic [DATA_W-1:0] tx_data;
  logic [KW-1:0]     tx_keep;
  logic              mode;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]  pkt_cnt, stall_cnt;

  logic dir_rdy, rand_rdy, rand_en;
  assign tx_ready = rand_en ? rand_rdy : dir_rdy;

  int checks   = 0;
  int failures = 0;

  echo_loopback_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_rx_TVALID (s_valid),
    .s_axis_rx_TREADY (s_ready),
    .s_axis_rx_TDATA  (s_data),
    .s_axis_rx_TKEEP  (s_keep),
    .s_axis_rx_TLAST  (s_last),
    .m_axis_tx_TVALID (tx_valid),
    .m_axis_tx_TREADY (tx_ready),
    .m_axis_tx_TDATA  (tx_data),
    .m_axis_tx_TKEEP  (tx_keep),
    .m_axis_tx_TLAST  (tx_last),
    .mode             (mode),
    .occupancy        (occupancy),
    .pkt_cnt          (pkt_cnt),
    .stall_cnt        (stall_cnt)
  );

  always #5 aclk = ~aclk;

  always begin
    @(posedge aclk);
    #1;
    rand_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and reference counters, owned by the monitor.
  beat_t       sb[$];
  int unsigned exp_occ;
  logic [CNT_W-1:0] exp_pkt, exp_stall;
  logic        tx_hold;
  beat_t       hold_beat;
  beat_t       exp_beat;

  always @(negedge aclk) begin
    if (aresetn !== 1'b1) begin
      sb.delete();
      exp_occ   = 0;
      exp_pkt   = '0;
      exp_stall = '0;
      tx_hold   = 1'b0;
    end else begin
      check("occupancy", occupancy, exp_occ);
      check("rx_ready", s_ready, exp_occ < DEPTH);
      check("pkt_cnt", pkt_cnt, exp_pkt);
      check("stall_cnt", stall_cnt, exp_stall);
      if (exp_occ == 0) check("tx_valid_empty", tx_valid, 1'b0);
      if (tx_hold) check("tx_stable", {tx_valid, tx_data, tx_keep, tx_last}, {1'b1, hold_beat});
      if (tx_valid && tx_ready) begin
        check("tx_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          check("tx_beat", {tx_data, tx_keep, tx_last}, exp_beat);
        end
        if (tx_last) exp_pkt = exp_pkt + 1'b1;
        exp_occ = exp_occ - 1;
      end
      if (s_valid && s_ready) begin
        sb.push_back({s_data, s_keep, s_last});
        exp_occ = exp_occ + 1;
      end
      if (s_valid && !s_ready && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
      tx_hold   = tx_valid && !tx_ready;
      hold_beat = {tx_data, tx_keep, tx_last};
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    mode    = m;
    s_valid = 1'b0;
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", s_ready, 1'b1);
    check("rst_occupancy", occupancy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    step();
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic l);
    s_valid = 1'b1;
    s_data  = rnd_data();
    s_keep  = KW'($urandom);
    s_last  = l;
  endtask

  // Holds the currently driven beat until it is accepted, then drops TVALID.
  task automatic hold_until_accepted();
    int n = 0;
    @(negedge aclk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge aclk);
    end
    check("rx_accept", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_beat(input logic l);
    drive(l);
    hold_until_accepted();
  endtask

  task automatic drain();
    int n = 0;
    @(negedge aclk);
    while ((occupancy != 0 || sb.size() != 0) && n < 400) begin
      n++;
      @(negedge aclk);
    end
    check("drain_occupancy", occupancy, 0);
    check("drain_scoreboard", sb.size(), 0);
    step();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    dir_rdy = 1'b1; rand_en = 1'b0; mode = 1'b0;

    // Pass-through: each beat visible on tx one cycle after acceptance.
    do_reset(1'b0);
    drive(1'b0);
    @(negedge aclk);
    check("pt_no_comb_path", tx_valid, 1'b0);
    step();
    drive(1'b0);
    @(negedge aclk);
    check("pt_d0_valid", tx_valid, 1'b1);
    step();
    drive(1'b1);
    @(negedge aclk);
    check("pt_d1_valid", tx_valid, 1'b1);
    step();
    s_valid = 1'b0;
    @(negedge aclk);
    check("pt_d2_last", {tx_valid, tx_last}, 2'b11);
    step();
    @(negedge aclk);
    check("pt_idle", tx_valid, 1'b0);
    check("pt_pkt_cnt", pkt_cnt, 1);
    step();

    // Store-and-forward: nothing leaves until TLAST is buffered, then 4 back-to-back beats.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) send_beat(1'b0);
    @(negedge aclk);
    check("sf_hold_valid", tx_valid, 1'b0);
    check("sf_hold_occ", occupancy, 3);
    step();
    send_beat(1'b1);
    @(negedge aclk);
    check("sf_release", {tx_valid, occupancy}, {1'b1, 5'd4});
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("sf_burst", tx_valid, 1'b1);
    end
    @(negedge aclk);
    check("sf_done", tx_valid, 1'b0);
    check("sf_pkt_cnt", pkt_cnt, 1);
    step();

    // Oversized packet in store-and-forward: released once the buffer fills.
    do_reset(1'b1);
    for (int i = 0; i < 15; i++) send_beat(1'b0);
    @(negedge aclk);
    check("big_hold", {tx_valid, occupancy}, {1'b0, 5'd15});
    step();
    send_beat(1'b0);
    @(negedge aclk);
    check("big_release", {tx_valid, occupancy}, {1'b1, 5'd16});
    step();
    for (int i = 16; i < 24; i++) send_beat(i == 23);
    drain();
    check("big_pkt_cnt", pkt_cnt, 1);

    // Backpressure: fill to DEPTH, stall long enough to saturate stall_cnt, then drain.
    dir_rdy = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) send_beat(1'b0);
    drive(1'b0);
    repeat (20) @(negedge aclk);
    check("full_rx_ready", s_ready, 1'b0);
    check("full_occupancy", occupancy, 16);
    check("stall_saturated", stall_cnt, 4'hf);
    step();
    dir_rdy = 1'b1;
    hold_until_accepted();
    send_beat(1'b0);
    send_beat(1'b0);
    send_beat(1'b1);
    drain();
    check("full_pkt_cnt", pkt_cnt, 1);

    // Reset mid-packet discards buffered beats; next packet echoes cleanly.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) send_beat(1'b0);
    @(negedge aclk);
    check("mid_occ", {tx_valid, occupancy}, {1'b0, 5'd5});
    step();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) send_beat(i == 2);
    drain();
    check("post_rst_pkt_cnt", pkt_cnt, 1);

    // Random handshakes on both sides; pkt_cnt wraps through the monitor's model.
    do_reset(1'b0);
    rand_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send_beat((i == 999) || ($urandom_range(0, 7) == 0));
    end
    rand_en = 1'b0;
    dir_rdy = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
